reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Consumer end of the reorder stage. Takes (grch, reordered position, sample) beats, writes each
//  sample into a ping-pong granule buffer at its position, and streams each completed
//  576-sample granule out in ascending index order. Output uses a valid/ready handshake.
//  Sits between the reorder/requantise path and the downstream stages (alias reduction, IMDCT).
// PARAMETERS
//  DATA_W     32   sample width in bits; stored and forwarded unmodified
//  FRAME_LEN  576  samples per granule/channel
//  FIFO_DEPTH 4    output skid FIFO depth; must be >= 4 (RAM latency 2 + 2)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       asynchronous reset, active-low (0 = reset)
//  grch_in     in   2       granule/channel tag of the input beat
//  pos_in      in   10      reordered sample position, 0..575
//  sample_in   in   DATA_W  sample value
//  din_v       in   1       input beat valid; no backpressure, every valid beat is consumed
//  grch_out    out  2       tag of the granule currently streaming
//  idx_out     out  10      index of sample_out, 0..575
//  sample_out  out  DATA_W  sample at idx_out
//  last_out    out  1       high with idx_out==575
//  dout_v      out  1       output valid
//  dout_ready  in   1       downstream ready; a transfer occurs when dout_v && dout_ready
//  overflow    out  1       sticky: beat dropped because both banks were full
//  pos_err     out  1       sticky: beat with pos_in >= FRAME_LEN, which is dropped
//  tag_err     out  1       sticky: grch_in changed before the granule's 576th beat
// BEHAVIOUR
//  Reset values: all outputs 0, both banks empty, write bank = 0, counters = 0.
//  Reset does not clear RAM contents. In-flight reads and FIFO contents are discarded.
//  Write side:
//   - wr_cnt counts accepted beats. On the first beat of a granule, grch is latched into the bank tag.
//   - Each accepted beat writes RAM[{wr_bank, pos_in}] = sample_in.
//   - When wr_cnt reaches 575 and a beat is accepted: set the bank's full flag, toggle wr_bank,
//     clear wr_cnt. That same beat is the last write to the old bank.
//   - A beat arriving while the target wr_bank is still full is dropped and sets overflow.
//     wr_cnt is unchanged.
//   - pos_in >= 576: beat dropped, pos_err set, wr_cnt unchanged.
//   - grch_in != latched tag mid-granule: tag_err set. The beat is still written and counted.
//  Read FSM, states IDLE -> PRIME -> STREAM -> IDLE:
//   - IDLE: rd_bank has its full flag set -> PRIME. Banks are read in fill order, starting with bank 0.
//   - PRIME/STREAM: issue a RAM read of {rd_bank, rd_idx} whenever
//     (fifo_count + reads_in_flight) < FIFO_DEPTH.
//   - rd_idx increments 0..575. The read of 575 moves the FSM to DRAIN (a wait state inside STREAM).
//   - The bank's full flag clears and rd_bank toggles when the sample tagged idx 575 leaves the
//     FIFO on a handshake. The FSM then returns to IDLE.
//  Latency:
//   - RAM read is 2 cycles (registered output). With dout_ready held high, the first dout_v
//     comes 3 cycles after the full flag sets.
//   - Throughput is then 1 sample/cycle: a granule streams in exactly 576 cycles.
//  Handshake:
//   - dout_v/grch_out/idx_out/sample_out/last_out hold stable while dout_v && !dout_ready.
//   - dout_v never drops without a handshake.
//  Boundary and simultaneous events:
//   - A bank completing on the same cycle the other bank's last sample handshakes: both take
//     effect. The FSM goes to IDLE, then PRIME next cycle. No beat is dropped.
//   - Write and read to the same bank never coincide, enforced by the full flags.
//   - Positions never written in a granule return stale RAM data. A permutation input is the caller's contract.
// STRUCTURE
//  mp3_pkg: FRAME_LEN=576, typedef logic [1:0] grch_t, typedef logic [9:0] sidx_t.
//  Storage: xilinx_simple_dual_port_1_clock_ram, depth 1024 ({bank, pos[8:0]} not valid, so use
//  {bank, pos} with 11-bit address, depth 2048), HIGH_PERFORMANCE.
//  Sub-module: rb_skid_fifo (sync FIFO holding {grch, idx, last, sample}, FIFO_DEPTH entries).
// TESTING
//  1. Beats for grch=1 with pos=575-k, sample=k, for k=0..575; ready=1 -> 576 outputs with
//     idx=i, sample=575-i, grch_out=1, last_out only at i=575; first dout_v 3 cycles after the 576th beat.
//  2. Random dout_ready at 30%, identity permutation -> output order and data intact; outputs
//     stable while stalled; exactly 576 handshakes.
//  3. Three granules back-to-back with dout_ready=0 -> granules 0 and 1 fill both banks; every
//     beat of granule 2 is dropped and overflow=1; after release, granules 0 then 1 stream out.
//  4. A beat with pos_in=600 mid-granule -> pos_err=1; the granule completes only after 576 valid beats.
//  5. grch_in switches 0->1 at beat 100 -> tag_err=1; grch_out=0 for the whole granule.
//  6. rst low for 1 cycle at output sample 200 -> dout_v=0 immediately, all flags cleared;
//     a new granule afterwards streams correctly from bank 0.

Source files
------------

// File: rtl/mp3_pkg.sv
// Shared types and constants for the granule datapath.
//   FRAME_LEN   : samples per granule/channel
//   grch_t      : granule/channel tag
//   sidx_t      : sample index / reordered position (0..575)
//   RD_*        : read-side FSM encodings of reorder_buffer
package mp3_pkg;
  localparam int FRAME_LEN = 576;

  typedef logic [1:0] grch_t;
  typedef logic [9:0] sidx_t;

  localparam sidx_t FRAME_LEN_S = sidx_t'(FRAME_LEN);
  localparam sidx_t LAST_IDX    = sidx_t'(FRAME_LEN - 1);

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_PRIME  = 2'd1;
  localparam logic [1:0] RD_STREAM = 2'd2;
  localparam logic [1:0] RD_DRAIN  = 2'd3;
endpackage

// File: rtl/rb_skid_fifo.sv
// Small synchronous FIFO that absorbs the RAM read pipeline when the
// downstream stalls. The writer must never push while full; the owner
// guarantees this through read credits.
// Ports: clk; rst async active-low; wr_en/wr_data push; rd_en pop request
//        (ignored while empty); rd_data head entry; count occupancy.
module rb_skid_fifo #(
  parameter int W     = 45,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/xilinx_simple_dual_port_1_clock_ram.sv
// Simple dual-port block RAM, one clock, high-performance read path.
// Read latency is 2 cycles: address -> ram_data register -> doutb register.
// Ports: clka clock; wea/addra/dina write port; enb/addrb read port;
//        regceb output register enable; doutb read data. Contents are never reset.
module xilinx_simple_dual_port_1_clock_ram #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 2048,
  localparam int ADDR_W = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 enb,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic                 regceb,
  output logic [RAM_WIDTH-1:0] doutb
);
  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clka) begin
    if (wea) bram[addra] <= dina;
    if (enb) ram_data <= bram[addrb];
  end

  always_ff @(posedge clka) begin
    if (regceb) doutb <= ram_data;
  end
endmodule

// File: rtl/reorder_buffer.sv
// Consumer end of the reorder stage: writes (grch, pos, sample) beats into a
// ping-pong granule RAM and streams each completed granule out in index order.
// Ports:
//   clk, rst (async, active-low)
//   grch_in, pos_in, sample_in, din_v : input beats, no backpressure
//   grch_out, idx_out, sample_out, last_out, dout_v, dout_ready : output stream
//   overflow, pos_err, tag_err : sticky error flags
//   rd_state : read FSM state (debug)
// Output handshake: a transfer happens on a clock edge where dout_v && dout_ready;
// while dout_v && !dout_ready all output fields hold, and dout_v only falls after
// a transfer.
module reorder_buffer
  import mp3_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        grch_in,
  input  logic [9:0]        pos_in,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              din_v,
  output logic [1:0]        grch_out,
  output logic [9:0]        idx_out,
  output logic [DATA_W-1:0] sample_out,
  output logic              last_out,
  output logic              dout_v,
  input  logic              dout_ready,
  output logic              overflow,
  output logic              pos_err,
  output logic              tag_err,
  output logic [1:0]        rd_state
);
  localparam int REC_W = 2 + 10 + 1 + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------- write side ----------------
  logic             wr_bank;
  sidx_t            wr_cnt;
  logic [1:0]       bank_full, bank_full_nxt;
  logic [1:0][1:0]  bank_tag;
  logic             pos_ok, accept, wr_done;

  assign pos_ok  = pos_in < FRAME_LEN_S;
  assign accept  = din_v && pos_ok && !bank_full[wr_bank];
  assign wr_done = accept && (wr_cnt == LAST_IDX);

  // ---------------- read side ----------------
  logic [1:0]       state;
  logic             rd_bank;
  sidx_t            rd_idx;
  logic             issue, room, pop, last_pop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             rd_v1, rd_v2, last1, last2;
  sidx_t            idx1, idx2;
  grch_t            grch1, grch2;
  logic [DATA_W-1:0] ram_dout;
  logic [REC_W-1:0]  fifo_rd;

  // Credits: FIFO entries plus reads still in the RAM pipeline may never exceed
  // the FIFO depth, so the FIFO can never be pushed while full.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(rd_v1) + (CNT_W+1)'(rd_v2);
  assign room      = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  // The first read is issued from IDLE on the cycle the full flag is seen;
  // waiting for PRIME would add a cycle to the first-output latency.
  always_comb begin
    issue = 1'b0;
    case (state)
      RD_IDLE:             issue = bank_full[rd_bank] && room;
      RD_PRIME, RD_STREAM: issue = room;
      default:             issue = 1'b0;
    endcase
  end

  assign pop      = dout_v && dout_ready;
  assign last_pop = pop && last_out;
  assign dout_v   = fifo_count != '0;
  assign rd_state = state;
  assign {grch_out, idx_out, last_out, sample_out} = fifo_rd;

  // Completion of one bank and release of the other may land on the same edge.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_done)  bank_full_nxt[wr_bank] = 1'b1;
    if (last_pop) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= '0;
      bank_tag  <= '0;
      overflow  <= 1'b0;
      pos_err   <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (din_v && !pos_ok) pos_err <= 1'b1;
      if (din_v && pos_ok && bank_full[wr_bank]) overflow <= 1'b1;
      if (accept) begin
        if (wr_cnt == '0) bank_tag[wr_bank] <= grch_in;
        else if (grch_in != bank_tag[wr_bank]) tag_err <= 1'b1;
        if (wr_done) begin
          wr_bank <= ~wr_bank;
          wr_cnt  <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      last1   <= 1'b0;
      last2   <= 1'b0;
      idx1    <= '0;
      idx2    <= '0;
      grch1   <= '0;
      grch2   <= '0;
    end else begin
      // Side data travels alongside the 2-cycle RAM read.
      rd_v1 <= issue;
      idx1  <= rd_idx;
      last1 <= rd_idx == LAST_IDX;
      grch1 <= bank_tag[rd_bank];
      rd_v2 <= rd_v1;
      idx2  <= idx1;
      last2 <= last1;
      grch2 <= grch1;

      if (issue) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;

      case (state)
        RD_IDLE:   if (issue) state <= RD_PRIME;
        RD_PRIME:  state <= RD_STREAM;
        RD_STREAM: if (issue && rd_idx == LAST_IDX) state <= RD_DRAIN;
        default: begin
          if (last_pop) begin
            state   <= RD_IDLE;
            rd_bank <= ~rd_bank;
          end
        end
      endcase
    end
  end

  xilinx_simple_dual_port_1_clock_ram #(
    .RAM_WIDTH(DATA_W),
    .RAM_DEPTH(2048)
  ) u_ram (
    .clka   (clk),
    .wea    (accept),
    .addra  ({wr_bank, pos_in}),
    .dina   (sample_in),
    .enb    (issue),
    .addrb  ({rd_bank, rd_idx}),
    .regceb (1'b1),
    .doutb  (ram_dout)
  );

  rb_skid_fifo #(
    .W    (REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (rd_v2),
    .wr_data({grch2, idx2, last2, ram_dout}),
    .rd_en  (dout_ready),
    .rd_data(fifo_rd),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int DATA_W = 32;
  localparam int REC_W  = 45;
  localparam int N      = 576;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        grch_in = '0;
  logic [9:0]        pos_in = '0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              din_v = 1'b0;
  logic [1:0]        grch_out;
  logic [9:0]        idx_out;
  logic [DATA_W-1:0] sample_out;
  logic              last_out, dout_v, overflow, pos_err, tag_err;
  logic              dout_ready = 1'b0;
  logic [1:0]        rd_state;

  reorder_buffer #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .grch_in(grch_in), .pos_in(pos_in), .sample_in(sample_in),
    .din_v(din_v), .grch_out(grch_out), .idx_out(idx_out), .sample_out(sample_out),
    .last_out(last_out), .dout_v(dout_v), .dout_ready(dout_ready), .overflow(overflow),
    .pos_err(pos_err), .tag_err(tag_err), .rd_state(rd_state)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ready_pct = 100;
  int hs_count = 0;
  int first_hs = 0;
  int last_hs = 0;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [REC_W-1:0] exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic int perm(input int kind, input int k);
    case (kind)
      0:       return k;
      1:       return 575 - k;
      default: return (k * 7) % 576;
    endcase
  endfunction

  // Which beat k lands at output index i (7*247 = 1 mod 576).
  function automatic int perm_inv(input int kind, input int i);
    case (kind)
      0:       return i;
      1:       return 575 - i;
      default: return (i * 247) % 576;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] g, input int kind, input logic [31:0] salt);
    for (int i = 0; i < N; i++)
      exp_q.push_back({g, 10'(i), (i == N - 1), salt + 32'(perm_inv(kind, i))});
  endtask

  task automatic send_beat(input logic [1:0] g, input logic [9:0] p, input logic [31:0] s);
    din_v = 1'b1; grch_in = g; pos_in = p; sample_in = s;
    @(posedge clk); #1;
    din_v = 1'b0;
  endtask

  task automatic send_granule(input logic [1:0] g, input int kind, input logic [31:0] salt);
    for (int k = 0; k < N; k++) send_beat(g, 10'(perm(kind, k)), salt + 32'(k));
  endtask

  // Called right after the completing beat's edge; returns edges until dout_v.
  task automatic measure_latency(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dout_v) begin lat = k - 1; break; end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk("drain", 64'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- ready driver ----------------
  initial forever begin
    @(posedge clk); #1;
    dout_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [REC_W-1:0] cur;
    if (!rst || !mon_en) prev_stall = 1'b0;
    else begin
      cur = {grch_out, idx_out, last_out, sample_out};
      if (prev_stall) begin
        chk("hold_valid", dout_v, 1);
        if (exp_q.size() != 0) chk("hold_data", cur, exp_q[0]);
      end
      if (dout_v && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out actual=0x%0h expected=none", cur);
        end else begin
          chk("out_rec", cur, exp_q.pop_front());
        end
        if (hs_count == 0) first_hs = cycle;
        last_hs = cycle;
        hs_count++;
      end
      prev_stall = dout_v && !dout_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  typedef struct {
    logic [1:0]  grch;
    int          kind;
    int          rdy;
    logic [31:0] salt;
    int          exp_latency;
    int          exp_hs;
    int          exp_span;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int n;
    vecs[0] = '{grch: 2'd1, kind: 1, rdy: 100, salt: 32'h0,    exp_latency: 3, exp_hs: 576, exp_span: 575};
    vecs[1] = '{grch: 2'd2, kind: 0, rdy: 30,  salt: 32'h1000, exp_latency: 3, exp_hs: 576, exp_span: -1};
    vecs[2] = '{grch: 2'd3, kind: 2, rdy: 100, salt: 32'h2000, exp_latency: 3, exp_hs: 576, exp_span: 575};
    vecs[3] = '{grch: 2'd0, kind: 2, rdy: 70,  salt: 32'h2800, exp_latency: 3, exp_hs: 576, exp_span: -1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {dout_v, overflow, pos_err, tag_err}, 0);
    chk("reset_data", {grch_out, idx_out, last_out, sample_out}, 0);
    chk("reset_state", rd_state, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Table: complete granules under several permutations and ready patterns.
    for (int v = 0; v < 4; v++) begin
      ready_pct = vecs[v].rdy;
      hs_count = 0;
      push_exp(vecs[v].grch, vecs[v].kind, vecs[v].salt);
      send_granule(vecs[v].grch, vecs[v].kind, vecs[v].salt);
      measure_latency(lat);
      chk("latency", 64'(lat), 64'(vecs[v].exp_latency));
      wait_drain(5000);
      chk("handshakes", 64'(hs_count), 64'(vecs[v].exp_hs));
      if (vecs[v].exp_span >= 0) chk("span", 64'(last_hs - first_hs), 64'(vecs[v].exp_span));
      chk("flags_clean", {overflow, pos_err, tag_err}, 0);
    end

    // Both banks full with the sink stalled; a third granule is dropped.
    ready_pct = 0;
    hs_count = 0;
    #20;
    push_exp(2'd0, 0, 32'h3000);
    push_exp(2'd1, 1, 32'h3100);
    send_granule(2'd0, 0, 32'h3000);
    send_granule(2'd1, 1, 32'h3100);
    chk("ovf_before", overflow, 0);
    send_granule(2'd2, 2, 32'h3200);
    chk("ovf_after", overflow, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("stalled_valid", dout_v, 1);
    chk("stalled_no_hs", 64'(hs_count), 0);
    ready_pct = 100;
    wait_drain(3000);
    chk("ovf_handshakes", 64'(hs_count), 1152);

    // Out-of-range position mid-granule.
    hs_count = 0;
    push_exp(2'd1, 0, 32'h4000);
    for (int k = 0; k < N - 1; k++) begin
      if (k == 300) send_beat(2'd1, 10'd600, 32'hdead);
      send_beat(2'd1, 10'(k), 32'h4000 + 32'(k));
    end
    chk("pos_err", pos_err, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("early_complete", dout_v, 0);
    send_beat(2'd1, 10'd575, 32'h4000 + 32'd575);
    wait_drain(2000);
    chk("pos_handshakes", 64'(hs_count), 576);
    chk("pos_no_tag_err", tag_err, 0);

    // Tag switch at beat 100; the latched tag wins.
    hs_count = 0;
    push_exp(2'd0, 1, 32'h5000);
    for (int k = 0; k < N; k++) begin
      if (k == 100) chk("tag_err_before", tag_err, 0);
      send_beat((k < 100) ? 2'd0 : 2'd1, 10'(575 - k), 32'h5000 + 32'(k));
      if (k == 100) chk("tag_err_after", tag_err, 1);
    end
    wait_drain(2000);
    chk("tag_handshakes", 64'(hs_count), 576);

    // Asynchronous reset in the middle of a stream.
    hs_count = 0;
    push_exp(2'd1, 0, 32'h6000);
    send_granule(2'd1, 0, 32'h6000);
    n = 0;
    while (hs_count < 200 && n < 2000) begin @(negedge clk); n++; end
    chk("reached_200", 64'(hs_count >= 200), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_dout_v", dout_v, 0);
    chk("rst_flags", {overflow, pos_err, tag_err}, 0);
    mon_en = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    chk("rst_state", rd_state, 0);
    hs_count = 0;
    push_exp(2'd2, 2, 32'h7000);
    send_granule(2'd2, 2, 32'h7000);
    measure_latency(lat);
    chk("post_rst_latency", 64'(lat), 3);
    wait_drain(2000);
    chk("post_rst_handshakes", 64'(hs_count), 576);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
